seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles each digit is lit per slot, legal range >=2.
REQ-003 Parameter GAP_CYC, default 16: all-dark cycles between digit slots (anti-ghosting); 0 means no gap.
REQ-004 Parameter HEX_MODE, default 0: 1 means codes 10..15 display as A,b,C,d,E,F; 0 means they display as dash (segment g only).
REQ-005 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-006 Port clk  in  1  system clock; all state updates on rising edge.
REQ-007 Port rst  in  1  reset, asynchronous, active-high.
REQ-008 Port enable  in  1  scan enable; 0 forces display dark.
REQ-009 Port load  in  1  single-cycle strobe capturing bcd_in/dp_in.
REQ-010 Port bcd_in  in  4*DIGITS  digit codes; digit i = bits [4i+3:4i]; digit 0 is least significant.
REQ-011 Port dp_in  in  DIGITS  decimal point request per digit.
REQ-012 Port seg  out  8  active-low segments; seg[0..6] = a..g, seg[7] = dp; 0 lights a segment.
REQ-013 Port an  out  DIGITS  active-low digit anodes; at most one bit 0 at any time.
REQ-014 Port frame_done  out  1  one-cycle pulse at the end of the last digit slot of each frame.

Function
REQ-015 Segment decode: 0..9 standard patterns, for example 0 -> seg[6:0]=7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000; 10..15 decode per HEX_MODE.
REQ-016 Pending register: on load=1, bcd_in/dp_in are captured into the pending register on that edge; back-to-back loads overwrite it, and the last load wins.
REQ-017 Active register: copied from the pending register only at frame boundaries, so a frame never shows mixed old/new data (no tearing).
REQ-018 Frame boundary: the cycle frame_done is asserted; the new data is lit from the next digit-0 slot.
REQ-019 FSM states: OFF, SHOW, GAP.
REQ-020 OFF: an all 1, seg all 1; go to SHOW for digit 0 when enable=1.
REQ-021 SHOW: the selected digit's anode is 0 and its pattern is driven; lasts exactly SCAN_DIV cycles, then goes to GAP (GAP_CYC>0) or directly to SHOW of the next digit.
REQ-022 GAP: an all 1, seg all 1; lasts exactly GAP_CYC cycles, then SHOW of the next digit.
REQ-023 Digit index increments 0 -> DIGITS-1, then wraps to 0.
REQ-024 frame_done is asserted on the final cycle of the last post-digit-(DIGITS-1) phase: the GAP if GAP_CYC>0, else the SHOW.
REQ-025 enable=0 in any state: go to OFF on the next edge, clear the scan counter, set digit index to 0; pending data is kept.
REQ-026 enable=0 with a pending update: the pending update is applied on the edge entering OFF.
REQ-027 Leading-zero blanking (BLANK_LZ=1): digits from DIGITS-1 downward whose code is 0, up to the first nonzero digit, are blanked (seg[6:0] all 1).
REQ-028 Digit 0 is never blanked; its dp is still shown if requested.
REQ-029 seg and an are registered outputs, with no combinational path from inputs.
REQ-030 The scan counter is wide enough for max(SCAN_DIV, GAP_CYC); no overflow occurs at any legal parameter value.
REQ-031 DIGITS=1: an[0] toggles only through GAP phases; frame_done pulses every slot.

Reset
REQ-032 While rst=1: seg=8'hFF, an all 1, frame_done=0, state OFF, digit index 0, counter 0, pending and active registers all zero.
REQ-033 Reset asserted mid-frame: outputs go dark immediately (asynchronously), with no completion of the current slot.
REQ-034 After rst falls with enable=1, the first SHOW of digit 0 starts on the first rising edge.

Verification (DIGITS=4, SCAN_DIV=4, GAP_CYC=1, HEX_MODE=0, BLANK_LZ=1 unless stated)
REQ-035 Reset, enable=1, load bcd_in=16'h1234, dp_in=0 -> after the first frame boundary, an sequence is 1110(4 cycles), 1111(1), 1101(4), 1111(1), 1011(4), 1111(1), 0111(4), 1111(1) with seg[6:0] = patterns 4,3,2,1; frame_done pulses every 20 cycles.
REQ-036 bcd_in=16'h0070, dp_in=4'b0001 -> digits 3 and 2 blanked, digit 1 shows 7, digit 0 shows 0 with seg[7]=0; repeat with BLANK_LZ=0 -> digits 3 and 2 show 0.
REQ-037 Load 16'h1111, then load 16'h2222 mid-frame -> the current frame shows all 1s, the next frame shows all 2s; no frame mixes the two values.
REQ-038 Code 4'hB: HEX_MODE=0 -> seg[6:0]=7'b0111111; HEX_MODE=1 -> 7'b0000011 (b).
REQ-039 enable deasserted during the SHOW of digit 2 -> OFF next edge (outputs dark); re-enable -> scan restarts at digit 0 with a full SCAN_DIV slot.
REQ-040 rst pulsed during GAP and during SHOW -> seg=8'hFF and an=4'hF within the same cycle, and display data is cleared to zero.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous data update.
// Ports: clk, rst (async high), enable, load, bcd_in, dp_in -> seg, an, frame_done.
module seg_scan_driver #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_CYC  = 16,
  parameter bit          HEX_MODE = 1'b0,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned MAXC = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
  localparam logic [6:0]    DASH      = 7'b0111111;

  typedef enum logic [1:0] {OFF, SHOW, GAP} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DW-1:0]         dig, dig_n;
  logic [4*DIGITS-1:0]   pend, act, act_n;
  logic [DIGITS-1:0]     pdp, adp, adp_n;
  logic [DIGITS-1:0]     blank;
  logic                  lz;
  logic [3:0]            code;
  logic [7:0]            seg_n;
  logic [DIGITS-1:0]     an_n;
  logic                  fd_n;

  function automatic logic [6:0] decode(input logic [3:0] c);
    if (!HEX_MODE && c > 4'd9) return DASH;
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Next state. Active data is refreshed from pending only when a frame
  // wraps, when the scan is stopped, or when it (re)starts from OFF.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dig_n   = dig;
    act_n   = act;
    adp_n   = adp;
    if (!enable) begin
      state_n = OFF;
      cnt_n   = '0;
      dig_n   = '0;
      act_n   = pend;
      adp_n   = pdp;
    end else begin
      unique case (state)
        OFF: begin
          state_n = SHOW;
          cnt_n   = '0;
          dig_n   = '0;
          act_n   = pend;
          adp_n   = pdp;
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_n = '0;
            if (GAP_CYC > 0) begin
              state_n = GAP;
            end else if (dig == DIG_LAST) begin
              dig_n = '0;
              act_n = pend;
              adp_n = pdp;
            end else begin
              dig_n = dig + DW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_n   = '0;
            state_n = SHOW;
            if (dig == DIG_LAST) begin
              dig_n = '0;
              act_n = pend;
              adp_n = pdp;
            end else begin
              dig_n = dig + DW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = OFF;
      endcase
    end
  end

  // Leading-zero mask, scanned from the most significant digit down.
  always_comb begin
    blank = '0;
    lz    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz       = lz && (act_n[4*i +: 4] == 4'd0);
      blank[i] = BLANK_LZ && lz;
    end
  end

  // Outputs are decoded from the next state so the registered pins line
  // up with the state they describe.
  always_comb begin
    seg_n = 8'hFF;
    an_n  = '1;
    code  = act_n[4*int'(dig_n) +: 4];
    if (state_n == SHOW) begin
      an_n[dig_n]  = 1'b0;
      seg_n[6:0]   = blank[dig_n] ? 7'h7F : decode(code);
      seg_n[7]     = ~adp_n[dig_n];
    end
    if (GAP_CYC > 0)
      fd_n = (state_n == GAP) && (dig_n == DIG_LAST) &&
             (cnt_n == GAP_LAST);
    else
      fd_n = (state_n == SHOW) && (dig_n == DIG_LAST) &&
             (cnt_n == SHOW_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OFF;
      cnt        <= '0;
      dig        <= '0;
      pend       <= '0;
      pdp        <= '0;
      act        <= '0;
      adp        <= '0;
      seg        <= 8'hFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dig        <= dig_n;
      act        <= act_n;
      adp        <= adp_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_done <= fd_n;
      if (load) begin
        pend <= bcd_in;
        pdp  <= dp_in;
      end
    end
  end

endmodule
